renode_ahb_buffered_subordinate: RTL and testbench

- Synthesizable AHB-Lite subordinate front-end for co-simulated peripherals.
- Converts AHB transfers into a generic valid/ready request channel with an in-order response channel, for the runtime-side or RTL responder.
- Writes are posted into a parametrised request FIFO, giving zero-wait-state writes until the FIFO is full.
- Reads stall until their in-order response returns. Supports any data width and any AHB transfer size up to the bus width.

---
 rtl/renode_ahb_buffered_subordinate_if.sv | 41 ++++
 rtl/renode_ahb_buffered_subordinate.sv | 162 ++++++++++++++++
 tb/tb_renode_ahb_buffered_subordinate.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/renode_ahb_buffered_subordinate_if.sv
// AHB-Lite subordinate bus plus the request/response channel toward the peripheral responder.
interface renode_ahb_buffered_subordinate_if #(
  parameter int unsigned AddressWidth = 32,
  parameter int unsigned DataWidth    = 32
);
  logic                    hsel;
  logic [AddressWidth-1:0] haddr;
  logic [1:0]              htrans;
  logic                    hwrite;
  logic [2:0]              hsize;
  logic [DataWidth-1:0]    hwdata;
  logic                    hready;
  logic                    hreadyout;
  logic                    hresp;
  logic [DataWidth-1:0]    hrdata;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_write;
  logic [AddressWidth-1:0]  req_addr;
  logic [2:0]               req_size;
  logic [DataWidth-1:0]     req_wdata;
  logic [DataWidth/8-1:0]   req_strb;
  logic                     rsp_valid;
  logic                     rsp_error;
  logic [DataWidth-1:0]     rsp_rdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata,
    output hreadyout, hresp, hrdata,
    output req_valid, req_write, req_addr, req_size, req_wdata, req_strb
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output req_ready, rsp_valid, rsp_error, rsp_rdata,
    input  hreadyout, hresp, hrdata,
    input  req_valid, req_write, req_addr, req_size, req_wdata, req_strb
  );
endinterface

// File: rtl/renode_ahb_buffered_subordinate.sv
// AHB-Lite subordinate that posts writes into a request FIFO and stalls reads until their
// in-order response returns; write responses are tracked by a pending counter.
module renode_ahb_buffered_subordinate #(
  parameter  int unsigned AddressWidth     = 32,
  parameter  int unsigned DataWidth        = 32,
  parameter  int unsigned FifoDepth        = 4,
  parameter  int unsigned MaxPendingWrites = 15,
  localparam int unsigned PendWidth        = $clog2(MaxPendingWrites + 1)
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  renode_ahb_buffered_subordinate_if.slave bus,
  output logic                 write_error,
  output logic [PendWidth-1:0] pending_writes
);
  localparam int unsigned NumLanes = DataWidth / 8;
  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic                    write;
    logic [AddressWidth-1:0] addr;
    logic [2:0]              size;
    logic [DataWidth-1:0]    wdata;
    logic [NumLanes-1:0]     strb;
  } req_t;

  typedef enum logic [2:0] {IDLE, WDATA, RD_WAIT, ERR1, ERR2} state_t;

  state_t                  state, accept_state;
  logic [AddressWidth-1:0] addr_q;
  logic [2:0]              size_q;
  logic                    rd_pushed;
  logic [DataWidth-1:0]    hrdata_q;
  req_t                    fifo_mem [FifoDepth];
  logic [PtrWidth-1:0]     wr_ptr, rd_ptr;
  logic [CntWidth-1:0]     count;

  logic [31:0]          lane_off, lane_bytes, lane_base;
  logic [NumLanes-1:0]  strb;
  logic [DataWidth-1:0] lane_mask;
  logic full, pop, push, wr_ready, wr_push, rd_push, wr_rsp, rd_rsp;
  logic accept, unsupported, data_done, hreadyout_c;
  req_t push_data, head;
  logic unused_htrans;

  // Byte lanes covered by the captured transfer; misaligned addresses round down to size alignment.
  always_comb begin
    lane_off   = 32'(addr_q % AddressWidth'(NumLanes));
    lane_bytes = 32'd1 << size_q;
    lane_base  = lane_off & ~(lane_bytes - 32'd1);
    for (int unsigned i = 0; i < NumLanes; i++) begin
      strb[i]              = (i >= lane_base) && (i < lane_base + lane_bytes);
      lane_mask[i*8 +: 8]  = {8{strb[i]}};
    end
  end

  assign unused_htrans = bus.htrans[0];
  assign accept        = bus.hsel & bus.hready & bus.htrans[1];
  assign unsupported   = (32'd1 << bus.hsize) > NumLanes;
  assign full          = (count == CntWidth'(FifoDepth));
  assign pop           = bus.req_valid & bus.req_ready;
  assign wr_ready      = !full && (pending_writes < PendWidth'(MaxPendingWrites));
  assign wr_push       = (state == WDATA) && wr_ready && bus.hready;
  assign rd_push       = (state == RD_WAIT) && !rd_pushed && (!full || bus.req_ready);
  assign push          = wr_push | rd_push;
  assign wr_rsp        = bus.rsp_valid && (pending_writes != '0);
  assign rd_rsp        = bus.rsp_valid && (pending_writes == '0) && (state == RD_WAIT) && rd_pushed;

  always_comb begin
    hreadyout_c = 1'b1;
    case (state)
      WDATA:         hreadyout_c = wr_ready;
      RD_WAIT, ERR1: hreadyout_c = 1'b0;
      default:       hreadyout_c = 1'b1;
    endcase
  end

  assign data_done = bus.hready & hreadyout_c;

  always_comb begin
    accept_state = IDLE;
    if (accept) begin
      if (unsupported)     accept_state = ERR1;
      else if (bus.hwrite) accept_state = WDATA;
      else                 accept_state = RD_WAIT;
    end
  end

  always_comb begin
    push_data.write = wr_push;
    push_data.addr  = addr_q;
    push_data.size  = size_q;
    push_data.wdata = wr_push ? (bus.hwdata & lane_mask) : '0;
    push_data.strb  = strb;
  end

  // Transfer FSM, FIFO pointers and posted-write bookkeeping.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state          <= IDLE;
      addr_q         <= '0;
      size_q         <= '0;
      rd_pushed      <= 1'b0;
      hrdata_q       <= '0;
      write_error    <= 1'b0;
      pending_writes <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
    end else begin
      write_error <= wr_rsp & bus.rsp_error;
      case ({wr_push, wr_rsp})
        2'b10:   pending_writes <= pending_writes + PendWidth'(1);
        2'b01:   pending_writes <= pending_writes - PendWidth'(1);
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
      case ({push, pop})
        2'b10:   count <= count + CntWidth'(1);
        2'b01:   count <= count - CntWidth'(1);
        default: ;
      endcase
      if (rd_push) rd_pushed <= 1'b1;

      if (data_done) begin
        state <= accept_state;
        if (accept) begin
          addr_q    <= bus.haddr;
          size_q    <= bus.hsize;
          rd_pushed <= 1'b0;
        end
      end else begin
        case (state)
          RD_WAIT: if (rd_rsp) begin
            state    <= bus.rsp_error ? ERR1 : IDLE;
            hrdata_q <= bus.rsp_error ? '0 : (bus.rsp_rdata & lane_mask);
          end
          ERR1:    state <= ERR2;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  assign head          = fifo_mem[rd_ptr];
  assign bus.req_valid = (count != '0);
  assign bus.req_write = head.write;
  assign bus.req_addr  = head.addr;
  assign bus.req_size  = head.size;
  assign bus.req_wdata = head.wdata;
  assign bus.req_strb  = head.strb;

  assign bus.hreadyout = hreadyout_c;
  assign bus.hresp     = (state == ERR1) || (state == ERR2);
  assign bus.hrdata    = hrdata_q;
endmodule

// File: tb/tb_renode_ahb_buffered_subordinate.sv
// Directed bench: lane/strobe vector table plus hand-written posted-write, stall, error and reset sequences.
module tb_renode_ahb_buffered_subordinate;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic       write_error;
  logic [3:0] pending_writes;

  renode_ahb_buffered_subordinate_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  renode_ahb_buffered_subordinate #(
    .AddressWidth(AW), .DataWidth(DW), .FifoDepth(4), .MaxPendingWrites(15)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .bus(bus.slave),
    .write_error(write_error), .pending_writes(pending_writes)
  );

  always #5 hclk = ~hclk;
  assign bus.hready = bus.hreadyout;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } seen_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
  } vec_t;

  seen_t       seen[$];
  int          werr_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  vec_t        vecs [9];

  // Log every request handed to the responder and count write_error pulses.
  always @(posedge hclk) begin
    if (hresetn && bus.req_valid && bus.req_ready)
      seen.push_back({bus.req_write, bus.req_addr, bus.req_wdata, bus.req_strb});
    if (write_error) werr_cnt <= werr_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic wait_ready(input string name, output int stalls);
    stalls = 0;
    while (!bus.hready && stalls < 60) begin
      tick();
      stalls++;
    end
    if (!bus.hready) begin
      checks++;
      errors++;
      $display("FAIL %s: hready still low after %0d cycles", name, stalls);
    end
  endtask

  task automatic pipelined_writes(input int n, input logic [2:0] size, output int stall_total);
    int s;
    stall_total = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1;
        bus.haddr = wr_addr[i]; bus.hsize = size;
      end else begin
        bus.hsel = 1'b0; bus.htrans = 2'b00;
      end
      if (i > 0) bus.hwdata = wr_data[i-1];
      wait_ready("write phase", s);
      stall_total += s;
      tick();
    end
  endtask

  task automatic read_addr(input logic [31:0] addr, input logic [2:0] size);
    int s;
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b0; bus.haddr = addr; bus.hsize = size;
    wait_ready("read addr", s);
    tick();
    bus.hsel = 1'b0; bus.htrans = 2'b00;
  endtask

  task automatic wait_seen(input int n);
    int c;
    c = 0;
    while (seen.size() < n && c < 60) begin
      tick();
      c++;
    end
    if (seen.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_req: %0d requests seen, want %0d", seen.size(), n);
    end
  endtask

  task automatic send_rsp(input logic err, input logic [31:0] rdata);
    bus.rsp_valid = 1'b1; bus.rsp_error = err; bus.rsp_rdata = rdata;
    tick();
    bus.rsp_valid = 1'b0; bus.rsp_error = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    int base;
    int werr0;

    vecs[0] = '{1'b1, 32'h40, 3'd2, 32'h11223344, 4'b1111, 32'h11223344};
    vecs[1] = '{1'b1, 32'h41, 3'd0, 32'hAABBCCDD, 4'b0010, 32'h0000CC00};
    vecs[2] = '{1'b1, 32'h46, 3'd1, 32'hAABBCCDD, 4'b1100, 32'hAABB0000};
    vecs[3] = '{1'b1, 32'h47, 3'd1, 32'h12345678, 4'b1100, 32'h12340000};
    vecs[4] = '{1'b1, 32'h45, 3'd2, 32'h12345678, 4'b1111, 32'h12345678};
    vecs[5] = '{1'b0, 32'h13, 3'd0, 32'hABCDEF01, 4'b1000, 32'hAB000000};
    vecs[6] = '{1'b0, 32'h22, 3'd1, 32'hABCDEF01, 4'b1100, 32'hABCD0000};
    vecs[7] = '{1'b0, 32'h30, 3'd0, 32'hABCDEF01, 4'b0001, 32'h00000001};
    vecs[8] = '{1'b0, 32'h34, 3'd2, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D};

    hresetn = 1'b0;
    bus.hsel = 1'b0; bus.htrans = 2'b00; bus.hwrite = 1'b0; bus.haddr = '0;
    bus.hsize = 3'd0; bus.hwdata = '0; bus.req_ready = 1'b1;
    bus.rsp_valid = 1'b0; bus.rsp_error = 1'b0; bus.rsp_rdata = '0;
    repeat (3) tick();
    hresetn = 1'b1;
    tick();

    check("reset hreadyout", 32'(bus.hreadyout), 32'd1);
    check("reset hresp", 32'(bus.hresp), 32'd0);
    check("reset hrdata", bus.hrdata, 32'd0);
    check("reset req_valid", 32'(bus.req_valid), 32'd0);
    check("reset write_error", 32'(write_error), 32'd0);
    check("reset pending", 32'(pending_writes), 32'd0);

    // Single transfers: strobe placement and lane masking
    for (int v = 0; v < 9; v++) begin
      base = seen.size();
      if (vecs[v].write) begin
        wr_addr[0] = vecs[v].addr;
        wr_data[0] = vecs[v].data;
        pipelined_writes(1, vecs[v].size, st);
      end else begin
        read_addr(vecs[v].addr, vecs[v].size);
      end
      wait_seen(base + 1);
      if (seen.size() > base) begin
        check($sformatf("vec%0d strb", v), 32'(seen[base].strb), 32'(vecs[v].exp_strb));
        check($sformatf("vec%0d addr", v), seen[base].addr, vecs[v].addr);
        check($sformatf("vec%0d dir", v), 32'(seen[base].write), 32'(vecs[v].write));
      end
      if (vecs[v].write) begin
        if (seen.size() > base)
          check($sformatf("vec%0d wdata", v), seen[base].wdata, vecs[v].exp_data);
        send_rsp(1'b0, '0);
        check($sformatf("vec%0d pending", v), 32'(pending_writes), 32'd0);
      end else begin
        send_rsp(1'b0, vecs[v].data);
        check($sformatf("vec%0d hrdata", v), bus.hrdata, vecs[v].exp_data);
        check($sformatf("vec%0d hreadyout", v), 32'(bus.hreadyout), 32'd1);
      end
    end

    // Four back-to-back writes with an always-ready responder
    base = seen.size();
    for (int i = 0; i < 4; i++) begin
      wr_addr[i] = 32'h100 + 32'(4 * i);
      wr_data[i] = 32'hA000_0000 + 32'(i);
    end
    pipelined_writes(4, 3'd2, st);
    check("b2b stalls", 32'(st), 32'd0);
    check("b2b pending peak", 32'(pending_writes), 32'd4);
    wait_seen(base + 4);
    for (int i = 0; i < 4; i++) begin
      if (seen.size() > base + i) begin
        check($sformatf("b2b addr%0d", i), seen[base+i].addr, wr_addr[i]);
        check($sformatf("b2b data%0d", i), seen[base+i].wdata, wr_data[i]);
      end
    end
    repeat (4) send_rsp(1'b0, '0);
    check("b2b pending drained", 32'(pending_writes), 32'd0);

    // Six writes into a stalled responder: fifth data phase waits for req_ready
    base = seen.size();
    bus.req_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_addr[i] = 32'h200 + 32'(4 * i);
      wr_data[i] = 32'h5000_0000 + 32'(i);
    end
    fork
      pipelined_writes(6, 3'd2, st);
      begin
        repeat (15) @(posedge hclk);
        #1;
        check("no pop while stalled", 32'(seen.size() - base), 32'd0);
        bus.req_ready = 1'b1;
      end
    join
    check("full fifo stalls", 32'(st > 0), 32'd1);
    check("six pending", 32'(pending_writes), 32'd6);
    wait_seen(base + 6);
    for (int i = 0; i < 6; i++) begin
      if (seen.size() > base + i)
        check($sformatf("stall order%0d", i), seen[base+i].addr, wr_addr[i]);
    end
    repeat (6) send_rsp(1'b0, '0);
    check("stall pending drained", 32'(pending_writes), 32'd0);

    // Two posted writes then a read; second write answers with error
    base = seen.size();
    werr0 = werr_cnt;
    wr_addr[0] = 32'h20; wr_data[0] = 32'h1;
    wr_addr[1] = 32'h24; wr_data[1] = 32'h2;
    pipelined_writes(2, 3'd2, st);
    read_addr(32'h10, 3'd2);
    wait_seen(base + 3);
    check("read waits", 32'(bus.hreadyout), 32'd0);
    if (seen.size() > base + 2) begin
      check("read req addr", seen[base+2].addr, 32'h10);
      check("read req dir", 32'(seen[base+2].write), 32'd0);
    end
    send_rsp(1'b0, '0);
    send_rsp(1'b1, '0);
    check("write_error pulse", 32'(write_error), 32'd1);
    send_rsp(1'b0, 32'hDEADBEEF);
    check("mixed hrdata", bus.hrdata, 32'hDEADBEEF);
    check("mixed hresp", 32'(bus.hresp), 32'd0);
    check("mixed hreadyout", 32'(bus.hreadyout), 32'd1);
    check("write_error count", 32'(werr_cnt - werr0), 32'd1);
    check("write_error cleared", 32'(write_error), 32'd0);

    // Transfer wider than the bus: two-cycle error, no request
    base = seen.size();
    bus.hsel = 1'b1; bus.htrans = 2'b10; bus.hwrite = 1'b1; bus.haddr = 32'h50; bus.hsize = 3'd3;
    wait_ready("wide addr", st);
    tick();
    bus.hsel = 1'b0; bus.htrans = 2'b00;
    check("err1 hresp", 32'(bus.hresp), 32'd1);
    check("err1 hreadyout", 32'(bus.hreadyout), 32'd0);
    tick();
    check("err2 hresp", 32'(bus.hresp), 32'd1);
    check("err2 hreadyout", 32'(bus.hreadyout), 32'd1);
    tick();
    check("post-err hresp", 32'(bus.hresp), 32'd0);
    repeat (3) tick();
    check("wide no request", 32'(seen.size() - base), 32'd0);
    check("wide pending", 32'(pending_writes), 32'd0);

    // Reset with queued writes and a stalled read
    bus.req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_addr[i] = 32'h300 + 32'(4 * i);
      wr_data[i] = 32'h7700_0000 + 32'(i);
    end
    pipelined_writes(3, 3'd2, st);
    read_addr(32'h400, 3'd2);
    tick();
    check("pre-reset stalled", 32'(bus.hreadyout), 32'd0);
    hresetn = 1'b0;
    tick();
    check("mid-reset hreadyout", 32'(bus.hreadyout), 32'd1);
    check("mid-reset req_valid", 32'(bus.req_valid), 32'd0);
    check("mid-reset pending", 32'(pending_writes), 32'd0);
    hresetn = 1'b1;
    bus.req_ready = 1'b1;
    tick();
    send_rsp(1'b1, 32'h1234);
    check("stale rsp write_error", 32'(write_error), 32'd0);
    check("stale rsp pending", 32'(pending_writes), 32'd0);
    check("stale rsp hreadyout", 32'(bus.hreadyout), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
